// File: rtl/rob_retire.sv
// In-order retirement at the ROB head: retires the longest completed prefix each cycle,
// writes the retirement RAT and flushes the pipeline for one cycle after a retired misprediction.
package rob_retire_pkg;
  typedef logic [4:0]  creg_addr_t;
  typedef logic [5:0]  preg_addr_t;
  typedef logic [31:0] pc_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t src;
    preg_addr_t psrc;
  } rat_wreq_t;
endpackage

module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int ROB_DEPTH    = 32,
  localparam int PW          = $clog2(ROB_DEPTH),
  localparam int RW          = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [PW:0]                         rob_count,
  input  logic [COMMIT_WIDTH-1:0]             slot_complete,
  input  logic [COMMIT_WIDTH-1:0]             slot_regwrite,
  input  creg_addr_t [COMMIT_WIDTH-1:0]       slot_creg,
  input  preg_addr_t [COMMIT_WIDTH-1:0]       slot_preg,
  input  logic [COMMIT_WIDTH-1:0]             slot_pd_fail,
  input  pc_t [COMMIT_WIDTH-1:0]              slot_correct_pc,
  input  logic                                commit_stall,
  output logic [PW-1:0]                       rob_head,
  output logic [RW-1:0]                       retire_num,
  output rat_wreq_t [COMMIT_WIDTH-1:0]        rat_wreq,
  output logic                                flush,
  output logic                                redirect_valid,
  output pc_t                                 redirect_pc,
  output logic [63:0]                         instret
);

  localparam int CW = PW + 1;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        rob_head_q, rob_head_d;
  logic [63:0]          instret_q, instret_d;
  pc_t                  redirect_pc_q, redirect_pc_d;

  logic [COMMIT_WIDTH-1:0] retire;
  logic                    blocked;
  logic                    mispredict;
  pc_t                     mispredict_pc;
  logic                    enable;
  logic [RW-1:0]           num;

  // Reset is folded into enable so nothing retires while resetn is held low.
  always_comb begin
    retire        = '0;
    blocked       = 1'b0;
    mispredict    = 1'b0;
    mispredict_pc = '0;
    num           = '0;
    enable        = resetn && (state_q == ST_RUN) && !commit_stall;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      if (enable && !blocked && (rob_count > CW'(i)) && slot_complete[i]) begin
        retire[i] = 1'b1;
        num       = num + RW'(1);
        if (slot_pd_fail[i]) begin
          blocked       = 1'b1;
          mispredict    = 1'b1;
          mispredict_pc = slot_correct_pc[i];
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      rat_wreq[i].valid = retire[i] && slot_regwrite[i] && (slot_creg[i] != '0);
      rat_wreq[i].src   = slot_creg[i];
      rat_wreq[i].psrc  = slot_preg[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    rob_head_d    = rob_head_q + PW'(num);
    instret_d     = instret_q + 64'(num);
    redirect_pc_d = redirect_pc_q;
    if (state_q == ST_FLUSH) begin
      state_d    = ST_RUN;
      rob_head_d = '0;
    end else if (mispredict) begin
      state_d       = ST_FLUSH;
      redirect_pc_d = mispredict_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_RUN;
      rob_head_q    <= '0;
      instret_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      rob_head_q    <= rob_head_d;
      instret_q     <= instret_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign retire_num     = num;
  assign rob_head       = rob_head_q;
  assign instret        = instret_q;
  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = (state_q == ST_FLUSH);
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_rob_retire.sv
// Scoreboard bench for rob_retire: a queue-level reference model predicts each cycle's
// outputs, and a monitor compares them against the DUT one cycle slot at a time.
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [5:0]            rob_count;
  logic [1:0]            slot_complete, slot_regwrite, slot_pd_fail;
  creg_addr_t [1:0]      slot_creg;
  preg_addr_t [1:0]      slot_preg;
  pc_t [1:0]             slot_correct_pc;
  logic                  commit_stall;
  logic [4:0]            rob_head;
  logic [1:0]            retire_num;
  rat_wreq_t [1:0]       rat_wreq;
  logic                  flush, redirect_valid;
  pc_t                   redirect_pc;
  logic [63:0]           instret;

  rob_retire #(.COMMIT_WIDTH(2), .ROB_DEPTH(32)) dut (
    .clk(clk), .resetn(resetn), .rob_count(rob_count),
    .slot_complete(slot_complete), .slot_regwrite(slot_regwrite),
    .slot_creg(slot_creg), .slot_preg(slot_preg), .slot_pd_fail(slot_pd_fail),
    .slot_correct_pc(slot_correct_pc), .commit_stall(commit_stall),
    .rob_head(rob_head), .retire_num(retire_num), .rat_wreq(rat_wreq),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rn;
    logic [1:0]  v;
    logic [9:0]  src;
    logic [11:0] psrc;
    logic [4:0]  head;
    logic [63:0] instret;
    logic        fl;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state
  int unsigned m_head;
  longint unsigned m_instret;
  bit          m_flush;
  logic [31:0] m_rpc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_head = 0; m_instret = 0; m_flush = 0; m_rpc = '0;
  endtask

  task automatic step(input int unsigned cnt, input logic [1:0] comp, input logic [1:0] rw,
                      input logic [4:0] c0, input logic [4:0] c1,
                      input logic [5:0] p0, input logic [5:0] p1,
                      input logic [1:0] pd, input logic [31:0] pc0, input logic [31:0] pc1,
                      input logic stall);
    exp_t e;
    int unsigned n;
    logic [4:0] cr[2];
    @(negedge clk);
    rob_count = 6'(cnt); slot_complete = comp; slot_regwrite = rw;
    slot_creg[0] = c0; slot_creg[1] = c1; slot_preg[0] = p0; slot_preg[1] = p1;
    slot_pd_fail = pd; slot_correct_pc[0] = pc0; slot_correct_pc[1] = pc1;
    commit_stall = stall;
    cr[0] = c0; cr[1] = c1;
    n = 0;
    if (!m_flush && !stall) begin
      while (n < 2 && n < cnt && comp[n]) begin
        n++;
        if (pd[n-1]) break;
      end
    end
    e.rn = 2'(n);
    for (int k = 0; k < 2; k++) e.v[k] = (k < n) && rw[k] && (cr[k] != 0);
    e.src = {c1, c0}; e.psrc = {p1, p0};
    e.head = 5'(m_head); e.instret = m_instret; e.fl = m_flush; e.rpc = m_rpc;
    q.push_back(e);
    if (m_flush) begin
      m_flush = 0; m_head = 0;
    end else begin
      m_head = (m_head + n) % 32;
      m_instret = m_instret + n;
      if (n > 0 && pd[n-1]) begin
        m_flush = 1;
        m_rpc = (n == 1) ? pc0 : pc1;
      end
    end
  endtask

  task automatic rand_step();
    logic [1:0] pd;
    pd[0] = ($urandom_range(0, 9) == 0);
    pd[1] = ($urandom_range(0, 9) == 0);
    step($urandom_range(0, 32), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11,
         2'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 5'($urandom),
         6'($urandom), 6'($urandom), pd, $urandom, $urandom,
         $urandom_range(0, 5) == 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("retire_num", 64'(retire_num), 64'(e.rn));
        chk("rat_valid", 64'({rat_wreq[1].valid, rat_wreq[0].valid}), 64'(e.v));
        chk("rat_src", 64'({rat_wreq[1].src, rat_wreq[0].src}), 64'(e.src));
        chk("rat_psrc", 64'({rat_wreq[1].psrc, rat_wreq[0].psrc}), 64'(e.psrc));
        chk("rob_head", 64'(rob_head), 64'(e.head));
        chk("instret", instret, e.instret);
        chk("flush", 64'(flush), 64'(e.fl));
        chk("redirect_valid", 64'(redirect_valid), 64'(e.fl));
        chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    resetn = 1'b0; rob_count = '0; slot_complete = '0; slot_regwrite = '0;
    slot_creg = '0; slot_preg = '0; slot_pd_fail = '0; slot_correct_pc = '0;
    commit_stall = 1'b0;
    model_reset();
    #12;
    chk("reset_head", 64'(rob_head), 64'd0);
    chk("reset_instret", instret, 64'd0);
    chk("reset_flush", 64'(flush), 64'd0);
    chk("reset_redirect_pc", 64'(redirect_pc), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed: prefix, zero creg, stall with mispredict, then mispredict with flush
    step(2, 2'b01, 2'b11, 5, 6, 10, 11, 2'b00, 0, 0, 0);
    step(2, 2'b11, 2'b11, 0, 7, 12, 13, 2'b00, 0, 0, 0);
    step(2, 2'b11, 2'b11, 3, 4, 14, 15, 2'b01, 32'h8000_1000, 0, 1);
    step(2, 2'b11, 2'b11, 3, 4, 14, 15, 2'b01, 32'h8000_1000, 0, 0);
    step(2, 2'b11, 2'b11, 8, 9, 16, 17, 2'b00, 0, 0, 0);
    step(2, 2'b11, 2'b11, 8, 9, 16, 17, 2'b00, 0, 0, 0);
    step(0, 2'b11, 2'b11, 8, 9, 16, 17, 2'b00, 0, 0, 0);
    step(32, 2'b11, 2'b01, 1, 2, 18, 19, 2'b10, 0, 32'h1234_5678, 0);

    for (int c = 0; c < 400; c++) rand_step();

    // Asynchronous reset while in FLUSH
    step(2, 2'b11, 2'b11, 1, 2, 3, 4, 2'b01, 32'hCAFE_0000, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_reset_flush", 64'(flush), 64'd1);
    resetn = 1'b0;
    #1;
    chk("async_flush", 64'(flush), 64'd0);
    chk("async_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("async_head", 64'(rob_head), 64'd0);
    chk("async_instret", instret, 64'd0);
    chk("async_redirect_pc", 64'(redirect_pc), 64'd0);
    slot_pd_fail = 2'b00;
    #1;
    chk("reset_retire_num", 64'(retire_num), 64'd0);
    chk("reset_rat_valid", 64'({rat_wreq[1].valid, rat_wreq[0].valid}), 64'd0);
    @(negedge clk);
    rob_count = '0;
    resetn = 1'b1;
    model_reset();

    for (int c = 0; c < 400; c++) rand_step();

    @(negedge clk);
    rob_count = '0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rob_retire.md
# rob_retire

In-order retirement stage at the read end of the reorder buffer. Each cycle it examines up to COMMIT_WIDTH entries starting at the ROB head and retires the longest prefix of completed entries. For each retired entry it drives the retirement-RAT write request (`rat_wreq_t`: creg → preg) and advances the head pointer. A retired mispredicted branch (`pd_fail`) starts a one-cycle pipeline flush with a PC redirect.

## Interface

Parameters:
- `COMMIT_WIDTH`, default 2: entries examined/retired per cycle.
- `ROB_DEPTH`, default 32: ROB entries; power of two; pointer width `PW = $clog2(ROB_DEPTH)`.

Ports (per-slot buses are indexed by `i` in `0..COMMIT_WIDTH-1`; slot `i` is the ROB entry at `(head + i) mod ROB_DEPTH`):
- `clk` in 1: clock, all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `rob_count` in PW+1: current ROB occupancy, 0..ROB_DEPTH.
- `slot_complete` in COMMIT_WIDTH: slot `i` has written back.
- `slot_regwrite` in COMMIT_WIDTH: slot `i` writes a destination register.
- `slot_creg` in COMMIT_WIDTH × `creg_addr_t`: architectural destination.
- `slot_preg` in COMMIT_WIDTH × `preg_addr_t`: physical destination.
- `slot_pd_fail` in COMMIT_WIDTH: branch misprediction flag from `entry_data_t.branch.extra.branch.pd_fail`.
- `slot_correct_pc` in COMMIT_WIDTH × `pc_t`: correct target for the slot.
- `commit_stall` in 1: blocks all retirement this cycle.
- `rob_head` out PW: head pointer; the ROB reads slots from it.
- `retire_num` out $clog2(COMMIT_WIDTH+1): entries retired this cycle.
- `rat_wreq` out COMMIT_WIDTH × `rat_wreq_t`: retirement-RAT writes, `{valid, src=creg, psrc=preg}`.
- `flush` out 1: squashes the ROB, rename and all pipeline stages.
- `redirect_valid` out 1: fetch redirect.
- `redirect_pc` out `pc_t`: redirect target.
- `instret` out 64: retired-instruction counter.

## Operation

- **States:** RUN and FLUSH.
- **Slot eligibility (RUN, `commit_stall`=0):** slot `i` retires iff all of the following hold:
  - `i < rob_count`;
  - `slot_complete[0..i]` are all 1;
  - no slot `j < i` has `slot_pd_fail[j]`=1.
- **Mispredicting slot:** a slot with `pd_fail` retires itself, but all later slots in the same cycle are blocked.
- **Retired count:** `retire_num` = count of retiring slots. Retiring slots always form a contiguous prefix.
- **RAT write:** `rat_wreq[i].valid` = retires(i) & `slot_regwrite[i]` & (`slot_creg[i]` ≠ 0).
  - When valid is 0, `src` and `psrc` still carry the slot fields.
  - Multiple valid requests to the same creg in one cycle are legal; the highest-index slot has priority. The RAT resolves this, and this block does not filter.
- **Head update:** `rob_head` ← (`rob_head` + `retire_num`) mod ROB_DEPTH. Wraps naturally at PW bits.
- **Counter:** `instret` ← `instret` + `retire_num`. Wraps at 2^64.
- **Misprediction entry to FLUSH:** when slot `k` retires with `pd_fail`=1, the block latches `slot_correct_pc[k]` and enters FLUSH.
- **FLUSH (exactly one cycle):**
  - `flush`=1, `redirect_valid`=1, `redirect_pc`=latched PC;
  - no slot retires, all `rat_wreq.valid`=0, `retire_num`=0;
  - inputs are ignored;
  - at the closing edge, `rob_head` ← 0, then state ← RUN.
- **`commit_stall`:** overrides eligibility entirely, with no retirement and no FLUSH entry. It has no effect while in FLUSH.
- **Empty ROB** (`rob_count`=0): nothing retires.
- **Full ROB:** no special case. Eligibility is still limited by `rob_count` ≥ COMMIT_WIDTH.

## Timing

- **Combinational outputs:** `rat_wreq` and `retire_num` are combinational from slot inputs, `rob_count`, `commit_stall` and state. They are valid in the same cycle the ROB presents slots.
- **Registered outputs:** `rob_head`, `instret`, state and the redirect PC.
- **`flush`/`redirect` latency:** asserted in the cycle after the mispredicting retire, for exactly one cycle. They are decoded from state, so they come from a register output.
- **First retire after flush:** the earliest new retire is 2 cycles after the mispredicting retire, provided the ROB has refilled.
- **Asynchronous reset** (`resetn`=0), including mid-FLUSH:
  - state=RUN, `rob_head`=0, `instret`=0, `redirect_pc`=0;
  - `flush`=0, `redirect_valid`=0;
  - `retire_num`=0 and all `rat_wreq.valid`=0 while reset is held.
- **Reset release:** the block is operational on the first rising edge after `resetn`=1.

## Test plan

- **Reset:** hold `resetn`=0 mid-FLUSH → `flush`=0, `rob_head`=0, `instret`=0 immediately (asynchronous, not at the next edge).
- **Prefix retire:** `rob_count`=2, complete=2'b01, both regwrite, creg 5/6 → `retire_num`=1, `rat_wreq[0]`={1,5,preg0}, `rat_wreq[1].valid`=0, `rob_head` 0→1.
- **Wrap:** `rob_head`=31, `rob_count`=2, both complete → `retire_num`=2, `rob_head`→1, `instret`+=2.
- **Misprediction:** slot0 pd_fail=1 with correct_pc=0x8000_1000, slot1 complete → `retire_num`=1, slot1 blocked. Next cycle `flush`=1, `redirect_pc`=0x8000_1000, `retire_num`=0. Following cycle: `rob_head`=0, `flush`=0.
- **Zero-register destination:** creg=0 with regwrite=1 → slot retires, `rat_wreq.valid`=0.
- **Stall:** `commit_stall`=1 with all slots complete and slot0 pd_fail=1 → `retire_num`=0, no flush. Deassert stall → retire and flush proceed normally.
